// File: rtl/fetch_trace_queue.sv
// Purpose : tracks every instruction-bus fetch in issue order until its inst_data_ok response returns.
// Latency : an entry can retire on the cycle after it is enqueued; retirement is combinational with inst_data_ok.
// Backpr. : SCT_allowin_w_o drops when DEPTH fetches are outstanding, unless a response frees a slot that cycle.
//
// Optional feature macro: SCT_REFILL_TRACK_EN keeps a per-entry TLB-refill flag and drives SCT_isRefill_o.
// Without it, no refill storage exists, SCT_isRefill_o is 0 and MMU_isRefill_i is ignored.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   FCT_*                     request from IF stage 1 (valid, payload, stage-1 exception, upstream cancel)
//   MMU_*                     MMU exception info, merged into the entry at enqueue
//   BSC/CP0/SBA cancel inputs pipeline-wide cancel, applied to every in-flight entry
//   inst_data_ok              bus response for the oldest outstanding request
//   SCT_allowin_w_o           queue can take a request this cycle
//   SCT_valid_o, SCT_*        head retirement strobe and head entry contents
//   SCT_count_o               current occupancy
module fetch_trace_queue #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 256,
  parameter int EXC_W     = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         FCT_valid_i,
  input  logic [PAYLOAD_W-1:0]         FCT_payload_i,
  input  logic                         FCT_hasException_i,
  input  logic [EXC_W-1:0]             FCT_ExcCode_i,
  input  logic                         FCT_isCanceled_i,
  input  logic                         MMU_hasException_i,
  input  logic [EXC_W-1:0]             MMU_ExcCode_i,
  input  logic                         MMU_isRefill_i,
  input  logic                         BSC_needCancel_w_i,
  input  logic                         CP0_excOccur_w_i,
  input  logic                         SBA_flush_w_i,
  input  logic                         inst_data_ok,
  output logic                         SCT_allowin_w_o,
  output logic                         SCT_valid_o,
  output logic [PAYLOAD_W-1:0]         SCT_payload_o,
  output logic                         SCT_hasException_o,
  output logic [EXC_W-1:0]             SCT_ExcCode_o,
  output logic                         SCT_isRefill_o,
  output logic [$clog2(DEPTH+1)-1:0]   SCT_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic             has_exc;
    logic [EXC_W-1:0] exc_code;
    logic             is_canceled;
  } meta_t;

  logic [PTR_W-1:0]     head_ptr, tail_ptr;
  logic [CNT_W-1:0]     count;
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  meta_t                meta_q    [DEPTH];

  logic  need_cancel, do_enq, do_pop;
  meta_t new_meta;

  assign need_cancel = BSC_needCancel_w_i | CP0_excOccur_w_i | SBA_flush_w_i;
  // A response that arrives with nothing outstanding is stray and must not move the head.
  assign do_pop      = inst_data_ok & (count != '0);
  // A full queue still accepts when a response frees the head slot in the same cycle.
  assign SCT_allowin_w_o = (count < CNT_W'(DEPTH)) | inst_data_ok;
  assign do_enq      = FCT_valid_i & SCT_allowin_w_o;

  // Stage-1 exceptions are older than MMU ones, so they win the code.
  assign new_meta.has_exc     = FCT_hasException_i | MMU_hasException_i;
  assign new_meta.exc_code    = FCT_hasException_i ? FCT_ExcCode_i : MMU_ExcCode_i;
  assign new_meta.is_canceled = FCT_isCanceled_i | need_cancel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        payload_q[i] <= '0;
        meta_q[i]    <= '0;
      end
    end else begin
      if (do_pop) head_ptr <= head_ptr + PTR_W'(1);
      if (do_enq) tail_ptr <= tail_ptr + PTR_W'(1);

      case ({do_enq, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // Marking free slots too is harmless: an enqueue rewrites every field.
      if (need_cancel) begin
        for (int i = 0; i < DEPTH; i++) meta_q[i].is_canceled <= 1'b1;
      end
      // Enqueue write comes last; its cancel bit already folds in need_cancel.
      if (do_enq) begin
        payload_q[tail_ptr] <= FCT_payload_i;
        meta_q[tail_ptr]    <= new_meta;
      end
    end
  end

  // Cancelled entries still drain on their response but never retire as valid.
  assign SCT_valid_o        = do_pop & ~meta_q[head_ptr].is_canceled & ~need_cancel;
  assign SCT_payload_o      = payload_q[head_ptr];
  assign SCT_hasException_o = meta_q[head_ptr].has_exc;
  assign SCT_ExcCode_o      = meta_q[head_ptr].exc_code;
  assign SCT_count_o        = count;

`ifdef SCT_REFILL_TRACK_EN
  logic refill_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) refill_q[i] <= 1'b0;
    end else if (do_enq) begin
      refill_q[tail_ptr] <= ~FCT_hasException_i & MMU_isRefill_i;
    end
  end

  assign SCT_isRefill_o = refill_q[head_ptr];
`else
  logic unused_refill;
  assign unused_refill  = MMU_isRefill_i;
  assign SCT_isRefill_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_trace_queue.sv
module tb_fetch_trace_queue;

  localparam int DEPTH = 4;
  localparam int PW    = 256;
  localparam int EW    = 5;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          fct_valid;
  logic [PW-1:0] fct_payload;
  logic          fct_exc;
  logic [EW-1:0] fct_code;
  logic          fct_can;
  logic          mmu_exc;
  logic [EW-1:0] mmu_code;
  logic          mmu_refill;
  logic          bsc_can, cp0_exc, sba_flush;
  logic          data_ok;
  logic          allowin, sct_valid, sct_exc, sct_refill;
  logic [PW-1:0] sct_payload;
  logic [EW-1:0] sct_code;
  logic [CW-1:0] sct_count;

  fetch_trace_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .EXC_W(EW)) dut (
    .clk                (clk),
    .rst                (rst),
    .FCT_valid_i        (fct_valid),
    .FCT_payload_i      (fct_payload),
    .FCT_hasException_i (fct_exc),
    .FCT_ExcCode_i      (fct_code),
    .FCT_isCanceled_i   (fct_can),
    .MMU_hasException_i (mmu_exc),
    .MMU_ExcCode_i      (mmu_code),
    .MMU_isRefill_i     (mmu_refill),
    .BSC_needCancel_w_i (bsc_can),
    .CP0_excOccur_w_i   (cp0_exc),
    .SBA_flush_w_i      (sba_flush),
    .inst_data_ok       (data_ok),
    .SCT_allowin_w_o    (allowin),
    .SCT_valid_o        (sct_valid),
    .SCT_payload_o      (sct_payload),
    .SCT_hasException_o (sct_exc),
    .SCT_ExcCode_o      (sct_code),
    .SCT_isRefill_o     (sct_refill),
    .SCT_count_o        (sct_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pl;
    logic          he;
    logic [EW-1:0] ec;
    logic          rf;
    logic          cn;
  } ent_t;

  ent_t mq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Called at posedge+1: drive one cycle of stimulus, check before the next edge, update the model.
  task automatic step(input logic v, input logic [PW-1:0] pl,
                      input logic fe, input logic [EW-1:0] fc, input logic fcan,
                      input logic me, input logic [EW-1:0] mc, input logic mr,
                      input logic [2:0] cn, input logic ok);
    logic nc, pop, allow, ev;
    ent_t e;
    fct_valid = v; fct_payload = pl; fct_exc = fe; fct_code = fc; fct_can = fcan;
    mmu_exc = me; mmu_code = mc; mmu_refill = mr;
    bsc_can = cn[0]; cp0_exc = cn[1]; sba_flush = cn[2];
    data_ok = ok;
    @(negedge clk); #1;
    nc    = |cn;
    pop   = ok && (mq.size() != 0);
    allow = (mq.size() < DEPTH) || ok;
    ev    = pop && !mq[0].cn && !nc;
    chk("count",   PW'(sct_count), PW'(mq.size()));
    chk("allowin", PW'(allowin),   PW'(allow));
    chk("valid",   PW'(sct_valid), PW'(ev));
    if (ev) begin
      chk("payload", sct_payload,      mq[0].pl);
      chk("has_exc", PW'(sct_exc),     PW'(mq[0].he));
      chk("exccode", PW'(sct_code),    PW'(mq[0].ec));
      chk("refill",  PW'(sct_refill),  PW'(mq[0].rf));
    end
    if (nc) foreach (mq[i]) mq[i].cn = 1'b1;
    if (pop) void'(mq.pop_front());
    if (v && allow) begin
      e.pl = pl;
      e.he = fe | me;
      e.ec = fe ? fc : mc;
`ifdef SCT_REFILL_TRACK_EN
      e.rf = !fe && mr;
`else
      e.rf = 1'b0;
`endif
      e.cn = fcan | nc;
      mq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic enq(input logic [PW-1:0] pl, input logic ok);
    step(1'b1, pl, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 3'b000, ok);
  endtask

  task automatic idle(input logic ok, input logic [2:0] cn);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, cn, ok);
  endtask

  task automatic chk_reset_outs();
    chk("rst_valid",   PW'(sct_valid),  '0);
    chk("rst_payload", sct_payload,     '0);
    chk("rst_exc",     PW'(sct_exc),    '0);
    chk("rst_code",    PW'(sct_code),   '0);
    chk("rst_refill",  PW'(sct_refill), '0);
    chk("rst_count",   PW'(sct_count),  '0);
    chk("rst_allowin", PW'(allowin),    PW'(1));
  endtask

  initial begin
    logic [PW-1:0] rp;
    rst = 1'b1;
    fct_valid = 0; fct_payload = '0; fct_exc = 0; fct_code = '0; fct_can = 0;
    mmu_exc = 0; mmu_code = '0; mmu_refill = 0;
    bsc_can = 0; cp0_exc = 0; sba_flush = 0; data_ok = 0;
    #12;
    chk_reset_outs();
    @(posedge clk); #1;
    rst = 1'b0;

    // In-order burst return
    enq(PW'('h11), 1'b0);
    enq(PW'('h22), 1'b0);
    enq(PW'('h33), 1'b0);
    idle(1'b1, 3'b000);
    idle(1'b1, 3'b000);
    idle(1'b1, 3'b000);
    idle(1'b0, 3'b000);

    // Full queue, rejected enqueue, then simultaneous pop+enqueue with wrap
    for (int i = 1; i <= 4; i++) enq(PW'('h40 + i), 1'b0);
    enq(PW'('h99), 1'b0);
    enq(PW'('h45), 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1, 3'b000);
    idle(1'b0, 3'b000);

    // Cancel in flight
    enq(PW'('h51), 1'b0);
    enq(PW'('h52), 1'b0);
    enq(PW'('h53), 1'b0);
    idle(1'b0, 3'b100);
    for (int i = 0; i < 3; i++) idle(1'b1, 3'b000);
    idle(1'b0, 3'b000);
    // Cancel coincident with a pop, and with an enqueue
    enq(PW'('h61), 1'b0);
    enq(PW'('h62), 1'b0);
    idle(1'b1, 3'b010);
    step(1'b1, PW'('h63), 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 3'b001, 1'b0);
    enq(PW'('h64), 1'b0);
    enq(PW'('h65), 1'b0);
    step(1'b1, PW'('h66), 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1, 3'b000);

    // Exception merge
    step(1'b1, PW'('h71), 1'b0, 5'h00, 1'b0, 1'b1, 5'h02, 1'b1, 3'b000, 1'b0);
    step(1'b1, PW'('h72), 1'b1, 5'h04, 1'b0, 1'b1, 5'h07, 1'b1, 3'b000, 1'b0);
    idle(1'b1, 3'b000);
    idle(1'b1, 3'b000);

    // Stray response on empty queue
    idle(1'b1, 3'b000);
    idle(1'b0, 3'b000);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < PW / 32; k++) rp[k*32 +: 32] = $urandom;
      step(1'($urandom_range(0, 1)), rp,
           1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
           1'($urandom_range(0, 1)));
    end
    while (mq.size() != 0) idle(1'b1, 3'b000);

    // Mid-operation reset with a response pending
    enq(PW'('h81), 1'b0);
    enq(PW'('h82), 1'b0);
    chk("pre_rst_count", PW'(sct_count), PW'(2));
    data_ok = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_reset_outs();
    mq.delete();
    @(posedge clk); #1;
    data_ok = 1'b0;
    rst = 1'b0;
    idle(1'b1, 3'b000);
    enq(PW'('h91), 1'b0);
    idle(1'b1, 3'b000);
    idle(1'b0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
